// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: opcode constants, fetch FSM states,
// default reset PC and the branch-immediate sign extension.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RETRY = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] sext_imm16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus; ready means the word is returned
// in the same cycle the request is accepted.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC select: jump beats taken branch beats sequential.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        unused_opcode;

  assign br_target     = pc_plus4 + (sext_imm16(instr[15:0]) << 2);
  assign j_target      = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jump)       next_pc = j_target;
    else if (pcsrc) next_pc = br_target;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-issue fetch stage: owns the PC, fetches over a ready handshake with
// timeout/retry, holds the word for the decoder until execute retires it.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master imem,
  input  logic               pcsrc,
  input  logic               jump,
  input  logic               ex_done,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [5:0]         opcode,
  output logic [5:0]         func,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               fetch_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Ready is checked before the timeout so a last-cycle response still lands.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RETRY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RETRY: state_d = FETCH;
      HOLD: begin
        if (ex_done) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  next_pc_calc u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .pcsrc    (pcsrc),
    .jump     (jump),
    .next_pc  (next_pc)
  );

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign opcode         = instr_q[31:26];
  assign func           = instr_q[5:0];
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign fetch_err      = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed corner sequences, a next-PC vector
// table, and randomized traffic checked against a transaction-level model.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] RPC     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcsrc, jump, ex_done;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, fetch_err;
  logic [5:0]  opcode, func;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .pcsrc(pcsrc), .jump(jump), .ex_done(ex_done),
    .instr(instr), .instr_valid(instr_valid), .opcode(opcode), .func(func),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  logic [31:0] t_pc4, t_instr, t_next;
  logic        t_ps, t_jp;
  next_pc_calc u_npc (
    .pc_plus4(t_pc4), .instr(t_instr), .pcsrc(t_ps), .jump(t_jp), .next_pc(t_next)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] salt = 32'h0;
  int          lat = 0;
  int          streak = 0;
  bit          noise = 1'b0;

  // Transaction-level model: a fetch is either pending (requesting, or in the
  // one-cycle back-off after a timeout) or completed and held.
  logic [31:0] m_pc, m_instr;
  bit          m_valid, m_pend, m_gap, m_err, m_idle;
  int          m_wait;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] ins;
    logic        ps;
    logic        jp;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ((a ^ salt) * 32'h9E37_79B1) + 32'h1234_5677;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input bit ps, input bit jp);
    logic [31:0] p4;
    int          off;
    p4 = cur + 32'd4;
    if (jp) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if (ps) begin
      off = int'($signed(ins[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  function automatic void model_reset();
    m_pc = RPC; m_instr = '0; m_valid = 0; m_pend = 0; m_gap = 0;
    m_err = 0; m_idle = 1; m_wait = 0;
  endfunction

  function automatic void model_edge(input bit rdy, input logic [31:0] w,
                                     input bit done, input bit ps, input bit jp);
    m_err = 0;
    if (m_idle) begin
      m_idle = 0; m_pend = 1; m_wait = 0;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_pend) begin
      if (rdy) begin
        m_instr = w; m_valid = 1; m_pend = 0; m_wait = 0;
      end else if (m_wait == TIMEOUT - 1) begin
        m_err = 1; m_gap = 1; m_wait = 0;
      end else begin
        m_wait++;
      end
    end else if (done) begin
      m_pc = ref_next(m_pc, m_instr, ps, jp);
      m_valid = 0; m_pend = 1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("req", 32'(bus.imem_req), 32'(m_pend && !m_gap && !m_idle));
    if (m_pend && !m_gap && !m_idle) chk("addr", bus.imem_addr, m_pc);
    chk("valid", 32'(instr_valid), 32'(m_valid));
    if (m_valid) begin
      chk("instr", instr, m_instr);
      chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
      chk("func", 32'(func), 32'(m_instr[5:0]));
    end
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
  endtask

  // One clock: drive memory and control, advance the model, sample after edge.
  task automatic step(input bit done, input bit ps, input bit jp);
    logic [31:0] w;
    bit          rdy;
    w = word_at(m_pc);
    bus.imem_rdata = word_at(bus.imem_addr);
    if (bus.imem_req) rdy = (streak >= lat);
    else              rdy = noise ? 1'($urandom) : 1'b0;
    bus.imem_ready = rdy;
    ex_done = done; pcsrc = ps; jump = jp;
    if (rst_n) model_edge(rdy, w, done, ps, jp);
    else       model_reset();
    streak = bus.imem_req ? streak + 1 : 0;
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic run_fetch(input bit pulse, output int reqc, output int errc);
    reqc = 0; errc = 0;
    for (int i = 0; i < 40 && !instr_valid; i++) begin
      reqc += int'(bus.imem_req);
      errc += int'(fetch_err);
      step(pulse && i[0], pulse, pulse);
    end
    chk("fetch_completes", 32'(instr_valid), 32'd1);
  endtask

  task automatic async_reset_check(input string nm);
    #3 rst_n = 1'b0;
    #1;
    chk({nm, "_req"}, 32'(bus.imem_req), 32'd0);
    chk({nm, "_valid"}, 32'(instr_valid), 32'd0);
    chk({nm, "_instr"}, instr, 32'd0);
    chk({nm, "_pc"}, pc, RPC);
    chk({nm, "_err"}, 32'(fetch_err), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0);
    chk({nm, "_restart_addr"}, bus.imem_addr, RPC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int reqc, errc, first, last, pulses, gaps;
    rst_n = 1'b0; ex_done = 0; pcsrc = 0; jump = 0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    model_reset();
    mem[32'h0]  = {OP_J, 26'h10};
    mem[32'h4]  = {OP_J, 26'h10};
    mem[32'h40] = {OP_BEQ, 5'd1, 5'd2, 16'hFFFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", instr, 32'd0);
    check_all();

    // Zero-wait memory from RESET_PC
    rst_n = 1'b1; lat = 0;
    step(0, 0, 0);
    chk("t1_req", 32'(bus.imem_req), 32'd1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    step(0, 0, 0);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, 32'h0800_0010);
    chk("t1_opcode", 32'(opcode), 32'(OP_J));
    step(1, 0, 0);
    chk("t1_next_addr", bus.imem_addr, 32'h4);
    step(0, 0, 0);
    chk("t1_done_to_valid", 32'(instr_valid), 32'd1);

    // Branches from pc=0x40
    step(0, 1, 1);
    chk("t2_ignored_ctrl", pc, 32'h4);
    step(1, 0, 1);
    step(0, 0, 0);
    mem[32'h40] = {OP_BEQ, 5'd1, 5'd2, 16'h0003};
    step(1, 1, 0);
    chk("t2_beq_back", pc, 32'h40);
    step(0, 0, 0);
    step(1, 1, 0);
    chk("t2_beq_fwd", pc, 32'h50);
    step(0, 0, 0);

    // Slow memory, ex_done pulses during FETCH ignored
    lat = 4;
    step(1, 0, 0);
    run_fetch(1, reqc, errc);
    chk("t4_req_cycles", 32'(reqc), 32'd5);
    chk("t4_no_err", 32'(errc), 32'd0);
    chk("t4_pc", pc, 32'h54);

    // Ready in the last cycle before timeout wins
    lat = TIMEOUT - 1;
    step(1, 0, 0);
    run_fetch(0, reqc, errc);
    chk("t4_edge_req_cycles", 32'(reqc), 32'(TIMEOUT));
    chk("t4_edge_no_err", 32'(errc), 32'd0);

    // Memory never ready: periodic timeouts
    lat = 100;
    step(1, 0, 0);
    first = -1; last = -1; pulses = 0; gaps = 0;
    for (int i = 0; i <= 50; i++) begin
      if (fetch_err) begin
        pulses++;
        if (first < 0) first = i;
        else chk("t5_period", 32'(i - last), 32'd17);
        last = i;
      end
      gaps += int'(!bus.imem_req);
      if (i < 50) step(0, 0, 0);
    end
    chk("t5_first_err", 32'(first), 32'd16);
    chk("t5_pulses", 32'(pulses), 32'd3);
    chk("t5_req_gaps", 32'(gaps), 32'd3);
    chk("t5_pc", pc, 32'h5C);

    // Async reset mid-FETCH, then mid-HOLD
    step(0, 0, 0);
    step(0, 0, 0);
    async_reset_check("t6_fetch");
    lat = 0;
    step(0, 0, 0);
    chk("t6_hold", 32'(instr_valid), 32'd1);
    async_reset_check("t6_hold");

    // Next-PC vector table
    tbl[0] = '{32'h0000_0044, {OP_BEQ, 5'd1, 5'd2, 16'hFFFF}, 1'b1, 1'b0, 32'h0000_0040};
    tbl[1] = '{32'h0000_0044, {OP_BEQ, 5'd1, 5'd2, 16'h0003}, 1'b1, 1'b0, 32'h0000_0050};
    tbl[2] = '{32'h1000_0044, {OP_J, 26'h100},                1'b1, 1'b1, 32'h1000_0400};
    tbl[3] = '{32'h1000_0044, {OP_J, 26'h100},                1'b0, 1'b0, 32'h1000_0044};
    tbl[4] = '{32'hFFFF_FFFC, {OP_BNE, 5'd3, 5'd3, 16'h0002}, 1'b1, 1'b0, 32'h0000_0004};
    tbl[5] = '{32'h0000_0004, {OP_BEQ, 5'd1, 5'd1, 16'hFFFE}, 1'b1, 1'b0, 32'hFFFF_FFFC};
    tbl[6] = '{32'hF000_0000, {OP_J, 26'h3FF_FFFF},           1'b0, 1'b1, 32'hFFFF_FFFC};
    tbl[7] = '{32'h8000_0000, {OP_BEQ, 5'd0, 5'd0, 16'h8000}, 1'b1, 1'b0, 32'h7FFE_0000};
    for (int i = 0; i < 8; i++) begin
      t_pc4 = tbl[i].pc4; t_instr = tbl[i].ins; t_ps = tbl[i].ps; t_jp = tbl[i].jp;
      #1;
      chk($sformatf("npc_vec%0d", i), t_next, tbl[i].exp);
    end

    // Randomized traffic against the model
    noise = 1'b1;
    salt = $urandom;
    for (int i = 0; i < 600; i++) begin
      bit d, p, j;
      if (!bus.imem_req) lat = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      d = ($urandom_range(0, 2) == 0);
      p = 1'($urandom);
      j = ($urandom_range(0, 3) == 0);
      step(d, p, j);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Single-issue instruction fetch stage that sits directly upstream of the main control decoder. It owns the PC, issues requests to instruction memory over a ready handshake, and holds the fetched word in an instruction register. It presents opcode/func to the decoder, then takes the decoder's pcsrc/jump results to form the next PC. It advances only when the execute stage signals completion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, cycles in FETCH without imem_ready before the request is retried
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
imem_req  out  1  instruction memory request
imem_addr  out  32  word address; equals pc while imem_req=1
imem_rdata  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  memory accepts the request and returns data in the same cycle
pcsrc  in  1  branch-taken flag from the decoder
jump  in  1  jump flag from the decoder
ex_done  in  1  one-cycle pulse: current instruction retired, PC may advance
instr  out  32  instruction register
instr_valid  out  1  instr holds a valid word
opcode  out  6  instr[31:26]
func  out  6  instr[5:0]
pc  out  32  address of the instruction in instr
pc_plus4  out  32  pc + 4, modulo 2^32
fetch_err  out  1  one-cycle pulse on each timeout

Behaviour:
- Reset (async assert; release synchronised by the flop): pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_valid=0, fetch_err=0, timeout counter=0. Asserting reset mid-operation aborts any fetch immediately; no partial instr update.
- FSM states: IDLE, FETCH, RETRY, HOLD.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH: imem_req=1 and imem_addr=pc, both driven from registered state.
  - imem_ready=1 at a clock edge: instr<=imem_rdata, instr_valid<=1, counter<=0, go to HOLD.
  - Otherwise the counter increments. When counter reaches TIMEOUT-1 without ready: fetch_err pulses for 1 cycle, counter<=0, go to RETRY.
- RETRY: imem_req=0 for exactly 1 cycle, then FETCH. pc is unchanged.
- HOLD: imem_req=0 and instr_valid=1. pcsrc/jump are sampled only in the cycle ex_done=1.
  - next_pc priority: jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else pcsrc -> pc_plus4 + (sign_extend(instr[15:0]) << 2); else pc_plus4.
  - All adds are 32-bit and wrap modulo 2^32.
  - On ex_done: pc<=next_pc, instr_valid<=0, go to FETCH. instr keeps its old value; it is don't-care while instr_valid=0.
- Latency:
  - imem_req rises 1 cycle after reset release.
  - instr_valid rises the cycle after ready is sampled.
  - The next request is issued the cycle after ex_done.
  - Zero-wait memory therefore gives 2 cycles from ex_done to instr_valid.
- Ignored inputs:
  - ex_done outside HOLD.
  - imem_ready outside FETCH.
  - pcsrc/jump when ex_done=0.
- Simultaneous pcsrc=1 and jump=1: jump wins.
- imem_ready arriving on the same edge the counter hits TIMEOUT-1: ready wins and no error is raised.
- opcode, func and pc_plus4 are combinational from instr/pc.

Decomposition:
- Shared package (cpu_pkg) holds:
  - Opcode constants OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, OP_LW=35, OP_SW=43.
  - The fetch-state enumeration.
  - A RESET_PC default.
- One natural sub-module: next_pc_calc, which is combinational. It takes pc_plus4, instr, pcsrc and jump and produces next_pc. Instantiate it once.
- The FSM, counter and registers stay in the top.

Test Plan:
1. Reset with RESET_PC=0 and zero-wait memory (ready=1 always) -> after release: imem_req=1 and addr=0. instr_valid=1 the next cycle with instr=mem[0]. Pulsing ex_done with pcsrc=jump=0 gives next addr=4.
2. pc=0x40, instr=BEQ with imm=0xFFFF, pcsrc=1, ex_done -> next pc=0x40 (0x44-4). With imm=0x0003 -> next pc=0x50.
3. pc=0x1000_0040, instr=J target 0x0000100, with jump=1 and pcsrc=1 together -> next pc=0x1000_0400 (jump priority, upper bits from pc_plus4).
4. Memory with ready delayed 5 cycles, TIMEOUT=16 -> imem_req held 5 cycles, no fetch_err. Extra ex_done pulses during FETCH leave pc unchanged.
5. Memory never ready, TIMEOUT=16 -> fetch_err pulses every 17 cycles (16 FETCH + 1 RETRY), imem_req low for 1 cycle each time, pc constant.
6. rst_n asserted asynchronously mid-FETCH and again mid-HOLD -> all outputs reach their reset values without waiting for a clock edge. After release, fetch restarts at RESET_PC.
